// File: rtl/raxm_pkg.sv
// Shared definitions for the RAXM accumulator: register map, CTRL/STATUS
// bit positions, FSM states and the result word type.
package raxm_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RES_LO = 4'h8;
    localparam logic [3:0] OFF_RES_HI = 4'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_LEN_LSB = 8;

    localparam int STAT_BUSY    = 4;
    localparam int STAT_UNF     = 8;
    localparam int STAT_CNT_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PUSH  = 2'd2
    } state_e;

    typedef logic [39:0] result_t;

endpackage

// File: rtl/raxm_acc_if.sv
// Wishbone slave bus plus product stream and interrupt of the accumulator.
interface raxm_acc_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        prod_valid_i;
    logic [31:0] prod_data_i;
    logic        prod_ready_o;
    logic        irq_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output prod_valid_i, prod_data_i,
        input  wbs_ack_o, wbs_dat_o, prod_ready_o, irq_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  prod_valid_i, prod_data_i,
        output wbs_ack_o, wbs_dat_o, prod_ready_o, irq_o
    );
endinterface

// File: rtl/raxm_res_fifo.sv
// Synchronous result FIFO; a pop frees space for a push in the same cycle.
module raxm_res_fifo
    import raxm_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  result_t       data_i,
    input  logic          pop_i,
    output result_t       data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    result_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o   = (count_q == CW'(0));
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    always_ff @(posedge clk_i) begin
        if (do_push_s && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/raxm_acc.sv
// Batch accumulator for approximate-multiplier products: sums LEN products
// into a 40-bit result, queues results, and exposes them over Wishbone.
module raxm_acc
    import raxm_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0100,
    parameter int          FIFO_DEPTH = 4
) (
    input logic        wb_clk_i,
    input logic        wb_rst_i,
    raxm_acc_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    result_t       acc_q;
    logic [8:0]    cnt_q;
    logic [8:0]    blen_q;
    logic          ready_q;
    logic          irq_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic          en_q, ie_q, unf_q, clr_q;
    logic [7:0]    len_q;

    logic          sel_s, acc_s, wr_s, rd_s, pop_s, xfer_s, push_ok_s;
    logic [3:0]    reg_off_s;
    logic [8:0]    len_full_s;
    logic [31:0]   rdata_d;
    result_t       head_s;
    logic          full_s, empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [2:0]    fcnt3_s;
    logic          unused_s;

    assign sel_s      = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign acc_s      = sel_s & ~ack_q;
    assign wr_s       = acc_s & bus.wbs_we_i;
    assign rd_s       = acc_s & ~bus.wbs_we_i;
    assign reg_off_s  = {bus.wbs_adr_i[3:2], 2'b00};
    assign pop_s      = rd_s & (reg_off_s == OFF_RES_LO) & ~empty_s;
    assign xfer_s     = ready_q & bus.prod_valid_i;
    assign push_ok_s  = (state_q == ST_PUSH) & (~full_s | pop_s);
    assign len_full_s = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
    assign fcnt3_s    = 3'(fifo_count_s);
    assign unused_s   = ^{bus.wbs_sel_i[3:2], bus.wbs_dat_i[31:16], bus.wbs_dat_i[7:3],
                          bus.wbs_adr_i[1:0]};

    raxm_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr_i   (clr_q),
        .push_i  (push_ok_s),
        .data_i  (acc_q),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (fifo_count_s)
    );

    // Register read mux; result words read as zero while the FIFO is empty.
    always_comb begin
        rdata_d = 32'h0;
        case (reg_off_s)
            OFF_CTRL: begin
                rdata_d[CTRL_EN]               = en_q;
                rdata_d[CTRL_IE]               = ie_q;
                rdata_d[CTRL_LEN_LSB +: 8]     = len_q;
            end
            OFF_STATUS: begin
                rdata_d[2:0]                   = fcnt3_s;
                rdata_d[STAT_BUSY]             = (state_q != ST_IDLE);
                rdata_d[STAT_UNF]              = unf_q;
                rdata_d[STAT_CNT_LSB +: 8]     = cnt_q[7:0];
            end
            OFF_RES_LO: begin
                if (empty_s) rdata_d = 32'h0;
                else         rdata_d = head_s[31:0];
            end
            OFF_RES_HI: begin
                if (empty_s) rdata_d = 32'h0;
                else         rdata_d = {24'h0, head_s[39:32]};
            end
            default: rdata_d = 32'h0;
        endcase
    end

    // Bus side: single-cycle ack, register writes and the sticky underflow flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            len_q <= 8'h0;
            unf_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ack_q <= acc_s;
            dat_q <= rd_s ? rdata_d : 32'h0;
            clr_q <= wr_s & (reg_off_s == OFF_CTRL) & bus.wbs_sel_i[0] & bus.wbs_dat_i[CTRL_CLR];
            if (wr_s && reg_off_s == OFF_CTRL) begin
                if (bus.wbs_sel_i[0]) begin
                    en_q <= bus.wbs_dat_i[CTRL_EN];
                    ie_q <= bus.wbs_dat_i[CTRL_IE];
                end
                if (bus.wbs_sel_i[1]) begin
                    len_q <= bus.wbs_dat_i[CTRL_LEN_LSB +: 8];
                end
            end
            if (wr_s && reg_off_s == OFF_STATUS && bus.wbs_sel_i[1] && bus.wbs_dat_i[STAT_UNF]) begin
                unf_q <= 1'b0;
            end else if (rd_s && reg_off_s == OFF_RES_LO && empty_s) begin
                unf_q <= 1'b1;
            end
        end
    end

    // Batch sequencer; LEN is latched only when a new batch starts.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_q) begin
            state_q <= ST_IDLE;
            acc_q   <= 40'h0;
            cnt_q   <= 9'd0;
            blen_q  <= 9'd0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q) begin
                        state_q <= ST_ACCUM;
                        acc_q   <= 40'h0;
                        cnt_q   <= 9'd0;
                        blen_q  <= len_full_s;
                        ready_q <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (!en_q) begin
                        state_q <= ST_IDLE;
                        acc_q   <= 40'h0;
                        cnt_q   <= 9'd0;
                        ready_q <= 1'b0;
                    end else if (xfer_s) begin
                        acc_q <= acc_q + {8'h0, bus.prod_data_i};
                        cnt_q <= cnt_q + 9'd1;
                        if ((cnt_q + 9'd1) == blen_q) begin
                            state_q <= ST_PUSH;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_PUSH: begin
                    if (push_ok_s) begin
                        if (en_q) begin
                            state_q <= ST_ACCUM;
                            acc_q   <= 40'h0;
                            cnt_q   <= 9'd0;
                            blen_q  <= len_full_s;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Result-available interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= ie_q & ~empty_s;
    end

    assign bus.wbs_ack_o    = ack_q;
    assign bus.wbs_dat_o    = dat_q;
    assign bus.prod_ready_o = ready_q;
    assign bus.irq_o        = irq_q;

endmodule

// File: tb/tb_raxm_acc.sv
// Self-checking bench for raxm_acc: batch vector table plus hand-written
// sequences for FIFO stall, 256-product batch, underflow, EN abort, CLR and reset.
module tb_raxm_acc;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    logic [39:0] sb_q[$];

    raxm_acc_if bus();

    raxm_acc #(.BASE_ADR(BASE), .FIFO_DEPTH(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  len;
        logic [31:0] p0, p1, p2;
        logic [39:0] sum;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                            input logic [3:0] sel, output logic [31:0] rd);
        logic got = 1'b0;
        rd = 32'h0;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;   bus.wbs_sel_i = sel;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                rd  = bus.wbs_dat_o;
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        if (!got) begin
            tests++; failed++;
            $display("FAIL ack_timeout: no ack at adr %0h", adr);
        end
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        wb_cycle(1'b1, BASE + {28'h0, off}, d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
        wb_cycle(1'b0, BASE + {28'h0, off}, 32'h0, 4'hF, d);
    endtask

    task automatic send_prod(input logic [31:0] d);
        logic ok = 1'b0;
        @(posedge clk); #1;
        bus.prod_valid_i = 1'b1; bus.prod_data_i = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.prod_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.prod_valid_i = 1'b0;
        if (!ok) begin
            tests++; failed++;
            $display("FAIL prod_timeout: product %0h not accepted", d);
        end
    endtask

    // Reads RES_HI then RES_LO and compares with the scoreboard head.
    task automatic read_result(input string name);
        logic [31:0] hi, lo;
        logic [39:0] e;
        if (sb_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            wb_read(4'hC, hi);
            check({name, "_hi"}, {32'h0, hi}, {56'h0, e[39:32]});
            wb_read(4'h8, lo);
            check({name, "_lo"}, {32'h0, lo}, {32'h0, e[31:0]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] p[3];
        int acks;

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        bus.prod_valid_i = 1'b0; bus.prod_data_i = 32'h0;

        vecs[0] = '{len: 8'd3, p0: 32'd10,         p1: 32'd20,         p2: 32'd30,         sum: 40'd60};
        vecs[1] = '{len: 8'd2, p0: 32'hFFFF_FFFF,  p1: 32'hFFFF_FFFF,  p2: 32'h0,          sum: 40'h1_FFFF_FFFE};
        vecs[2] = '{len: 8'd3, p0: 32'h8000_0000,  p1: 32'h8000_0000,  p2: 32'h8000_0000,  sum: 40'h1_8000_0000};
        vecs[3] = '{len: 8'd1, p0: 32'd7,          p1: 32'h0,          p2: 32'h0,          sum: 40'd7};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",   {63'h0, bus.wbs_ack_o},    64'h0);
        check("rst_dat",   {32'h0, bus.wbs_dat_o},    64'h0);
        check("rst_ready", {63'h0, bus.prod_ready_o}, 64'h0);
        check("rst_irq",   {63'h0, bus.irq_o},        64'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Table-driven batches.
        for (int i = 0; i < 4; i++) begin
            p[0] = vecs[i].p0; p[1] = vecs[i].p1; p[2] = vecs[i].p2;
            wb_write(4'h0, 32'h0);
            wb_write(4'h0, {16'h0, vecs[i].len, 8'h05});
            for (int k = 0; k < int'(vecs[i].len); k++) send_prod(p[k]);
            sb_q.push_back(vecs[i].sum);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("vec_irq_hi", {63'h0, bus.irq_o}, 64'h1);
            wb_read(4'h4, rd);
            check("vec_status", {32'h0, rd}, 64'h11);
            read_result("vec_res");
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("vec_irq_lo", {63'h0, bus.irq_o}, 64'h0);
        end

        // CLR empties the FIFO and reads back as 0.
        wb_write(4'h0, 32'h0);
        wb_write(4'h0, 32'h0000_0105);
        send_prod(32'd9);
        repeat (3) @(posedge clk);
        wb_read(4'h4, rd);
        check("clr_pre_cnt", {61'h0, rd[2:0]}, 64'h1);
        wb_write(4'h0, 32'h0000_0107);
        wb_read(4'h4, rd);
        check("clr_cnt", {61'h0, rd[2:0]}, 64'h0);
        wb_read(4'h0, rd);
        check("clr_ctrl", {32'h0, rd}, 64'h105);

        // LEN=1, five products: fifth held in PUSH until a pop frees a slot.
        for (int k = 0; k < 5; k++) begin
            send_prod(32'hFFFF_FFFF);
            sb_q.push_back(40'h00_FFFF_FFFF);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_ready", {63'h0, bus.prod_ready_o}, 64'h0);
        wb_read(4'h4, rd);
        check("stall_status", {32'h0, rd}, 64'h0001_0014);
        read_result("stall_pop");
        wb_read(4'h4, rd);
        check("stall_after", {32'h0, rd}, 64'h0000_0014);
        wb_write(4'h0, 32'h0);
        for (int k = 0; k < 4; k++) read_result("stall_drain");
        wb_read(4'h4, rd);
        check("stall_empty", {32'h0, rd}, 64'h0);

        // LEN=0 means a 256-product batch.
        wb_write(4'h0, 32'h0000_0005);
        for (int k = 0; k < 256; k++) send_prod(32'hFFFF_FFFF);
        sb_q.push_back(40'hFF_FFFF_FF00);
        repeat (3) @(posedge clk);
        read_result("len256");
        wb_write(4'h0, 32'h0);

        // Underflow is sticky until written with 1.
        wb_read(4'h8, rd);
        check("unf_data", {32'h0, rd}, 64'h0);
        wb_read(4'h4, rd);
        check("unf_set", {63'h0, rd[8]}, 64'h1);
        wb_write(4'h4, 32'h0000_0100);
        wb_read(4'h4, rd);
        check("unf_clr", {63'h0, rd[8]}, 64'h0);

        // EN dropped mid-batch discards the partial sum.
        wb_write(4'h0, 32'h0000_0305);
        send_prod(32'd100);
        send_prod(32'd200);
        wb_read(4'h4, rd);
        check("abort_mid", {32'h0, rd}, 64'h0002_0010);
        wb_write(4'h0, 32'h0000_0300);
        repeat (2) @(posedge clk);
        wb_read(4'h4, rd);
        check("abort_idle", {63'h0, rd[4]}, 64'h0);
        wb_write(4'h0, 32'h0000_0305);
        send_prod(32'd5); send_prod(32'd6); send_prod(32'd7);
        sb_q.push_back(40'd18);
        repeat (3) @(posedge clk);
        wb_read(4'h4, rd);
        check("abort_cnt", {61'h0, rd[2:0]}, 64'h1);
        read_result("abort_res");

        // Reset during a pending read drops the ack.
        wb_write(4'h0, 32'h0);
        wb_write(4'h0, 32'h0000_0105);
        send_prod(32'd42);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("prerst_irq", {63'h0, bus.irq_o}, 64'h1);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE + 32'h8; bus.wbs_sel_i = 4'hF;
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        check("rst_read_noack", acks, 64'h0);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("rst2_dat",   {32'h0, bus.wbs_dat_o},    64'h0);
        check("rst2_ready", {63'h0, bus.prod_ready_o}, 64'h0);
        check("rst2_irq",   {63'h0, bus.irq_o},        64'h0);
        @(posedge clk); #1; rst = 1'b0;
        sb_q.delete();
        wb_read(4'h0, rd);
        check("rst2_ctrl", {32'h0, rd}, 64'h0);
        wb_read(4'h4, rd);
        check("rst2_status", {32'h0, rd}, 64'h0);

        // Address just past the window is never acked.
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE + 32'h10;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check("oor_noack", acks, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
